// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the parameterised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // The occupancy counter must be able to represent DEPTH itself, so it needs one extra code.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ptr_width(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [ptr_width(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]             rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO: pointer/count control, threshold flags and error pulses around fifo_mem.
// FWFT selects a registered read port (0) or a first-word-fall-through head view (1).
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr,
  input  logic                        rd,
  input  logic [WIDTH-1:0]            data_in,
  output logic [WIDTH-1:0]            data_out,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [cnt_width(DEPTH)-1:0] fifo_cnt,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int CW = cnt_width(DEPTH);
  localparam int AW = ptr_width(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [CW-1:0]    cnt_q, cnt_next;
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic             rd_ok, wr_ok;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] dout_q;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == CNT_FULL);
  assign almost_full  = (cnt_q >= CNT_AF);
  assign almost_empty = (cnt_q <= CNT_AE);
  assign fifo_cnt     = cnt_q;

  // A read frees a slot for a same-cycle write, but a write never makes an empty FIFO readable.
  always_comb begin
    rd_ok       = rd && !empty;
    wr_ok       = wr && (!full || rd_ok);
    cnt_next    = cnt_q;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (wr_ok) wr_ptr_next = ptr_inc(wr_ptr);
    if (rd_ok) rd_ptr_next = ptr_inc(rd_ptr);
    if (wr_ok && !rd_ok) cnt_next = cnt_q + CW'(1);
    else if (rd_ok && !wr_ok) cnt_next = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      cnt_q     <= cnt_next;
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      overflow  <= wr && !wr_ok;
      underflow <= rd && !rd_ok;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok && !rst),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Remember the last visible head so data_out stays stable once the FIFO drains.
      always_ff @(posedge clk) begin
        if (rst)         dout_q <= '0;
        else if (!empty) dout_q <= head;
      end
      assign data_out = empty ? dout_q : head;
    end else begin : g_registered
      always_ff @(posedge clk) begin
        if (rst)        dout_q <= '0;
        else if (rd_ok) dout_q <= head;
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a registered-read and an FWFT instance share stimulus and are
// compared against a queue-based reference model of the FIFO rules.
module tb_sync_fifo_param;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, wr, rd;
  logic [7:0] data_in;

  logic [7:0] r_dout, f_dout;
  logic       r_empty, r_full, r_ae, r_af, r_ovf, r_unf;
  logic       f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [3:0] r_cnt, f_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] exp_dout;
  logic       exp_ovf, exp_unf;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .data_in(data_in), .data_out(r_dout),
    .empty(r_empty), .full(r_full), .almost_empty(r_ae), .almost_full(r_af),
    .fifo_cnt(r_cnt), .overflow(r_ovf), .underflow(r_unf)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .data_in(data_in), .data_out(f_dout),
    .empty(f_empty), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
    .fifo_cnt(f_cnt), .overflow(f_ovf), .underflow(f_unf)
  );

  // Drive one cycle, advance the model at the edge, then settle for sampling.
  task automatic tick(input logic w, input logic r, input logic [7:0] d);
    bit rd_acc, wr_acc;
    wr = w; rd = r; data_in = d;
    @(posedge clk);
    if (rst) begin
      q.delete(); exp_dout = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;
    end else begin
      rd_acc  = r && (q.size() > 0);
      wr_acc  = w && ((q.size() < DEPTH) || rd_acc);
      exp_ovf = w && !wr_acc;
      exp_unf = r && !rd_acc;
      if (rd_acc) exp_dout = q.pop_front();
      if (wr_acc) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b1, 1'b1, 8'hAA);
    tick(1'b1, 1'b1, 8'hBB);
    checks++; if (r_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d exp 0", r_cnt); end
    checks++; if (r_empty !== 1'b1 || r_ae !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty_ae: got %b%b exp 11", r_empty, r_ae); end
    checks++; if (r_full !== 1'b0 || r_af !== 1'b0) begin errors++; $display("[TB] FAIL reset_full_af: got %b%b exp 00", r_full, r_af); end
    checks++; if (r_ovf !== 1'b0 || r_unf !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got %b%b exp 00", r_ovf, r_unf); end
    checks++; if (r_dout !== 8'h00 || f_dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout: got %h/%h exp 00/00", r_dout, f_dout); end
    rst = 1'b0;
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 1'b0, 8'(i + 1));
      checks++; if (r_cnt !== 4'(i + 1)) begin errors++; $display("[TB] FAIL fill_cnt: got %0d exp %0d", r_cnt, i + 1); end
      checks++; if (r_ae !== (i + 1 <= 2)) begin errors++; $display("[TB] FAIL fill_ae: got %b at cnt %0d", r_ae, i + 1); end
      checks++; if (r_af !== (i + 1 >= 6)) begin errors++; $display("[TB] FAIL fill_af: got %b at cnt %0d", r_af, i + 1); end
      checks++; if (r_full !== (i + 1 == DEPTH) || r_empty !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_empty: got %b%b at cnt %0d", r_full, r_empty, i + 1); end
      checks++; if (f_dout !== 8'h01) begin errors++; $display("[TB] FAIL fill_fwft_head: got %h exp 01", f_dout); end
    end
  endtask

  task automatic test_overflow();
    tick(1'b1, 1'b0, 8'hFF);
    checks++; if (r_ovf !== 1'b1 || f_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pulse: got %b/%b exp 1", r_ovf, f_ovf); end
    checks++; if (r_cnt !== 4'd8) begin errors++; $display("[TB] FAIL ovf_cnt: got %0d exp 8", r_cnt); end
    tick(1'b0, 1'b0, 8'h00);
    checks++; if (r_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_single: got %b exp 0", r_ovf); end
  endtask

  task automatic test_full_rw();
    tick(1'b1, 1'b1, 8'h09);
    checks++; if (r_cnt !== 4'd8 || r_full !== 1'b1) begin errors++; $display("[TB] FAIL fullrw_cnt: got %0d full %b exp 8 1", r_cnt, r_full); end
    checks++; if (r_ovf !== 1'b0) begin errors++; $display("[TB] FAIL fullrw_ovf: got %b exp 0", r_ovf); end
    checks++; if (r_dout !== 8'h01) begin errors++; $display("[TB] FAIL fullrw_first: got %h exp 01", r_dout); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (f_dout !== 8'(i + 2)) begin errors++; $display("[TB] FAIL drain_fwft: got %h exp %h", f_dout, 8'(i + 2)); end
      tick(1'b0, 1'b1, 8'h00);
      checks++; if (r_dout !== 8'(i + 2) || r_dout !== exp_dout) begin errors++; $display("[TB] FAIL drain_data: got %h exp %h", r_dout, 8'(i + 2)); end
    end
    checks++; if (r_empty !== 1'b1 || r_cnt !== 4'd0) begin errors++; $display("[TB] FAIL drain_empty: got %b cnt %0d exp 1 0", r_empty, r_cnt); end
  endtask

  task automatic test_underflow();
    tick(1'b0, 1'b1, 8'h00);
    checks++; if (r_unf !== 1'b1 || f_unf !== 1'b1) begin errors++; $display("[TB] FAIL unf_pulse: got %b/%b exp 1", r_unf, f_unf); end
    checks++; if (r_cnt !== 4'd0 || r_dout !== 8'h09) begin errors++; $display("[TB] FAIL unf_hold: got cnt %0d dout %h exp 0 09", r_cnt, r_dout); end
    tick(1'b1, 1'b1, 8'h5A);
    checks++; if (r_cnt !== 4'd1 || r_unf !== 1'b1) begin errors++; $display("[TB] FAIL empty_rw: got cnt %0d unf %b exp 1 1", r_cnt, r_unf); end
    checks++; if (f_dout !== 8'h5A) begin errors++; $display("[TB] FAIL empty_rw_fwft: got %h exp 5a", f_dout); end
    tick(1'b0, 1'b1, 8'h00);
    checks++; if (r_dout !== 8'h5A || r_unf !== 1'b0 || r_cnt !== 4'd0) begin errors++; $display("[TB] FAIL empty_rw_read: got %h unf %b cnt %0d exp 5a 0 0", r_dout, r_unf, r_cnt); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1, 8'(8'h10 + i));
      checks++; if (r_cnt !== 4'd4) begin errors++; $display("[TB] FAIL wrap_cnt: got %0d exp 4", r_cnt); end
      checks++; if (r_dout !== exp_dout) begin errors++; $display("[TB] FAIL wrap_data: got %h exp %h", r_dout, exp_dout); end
      checks++; if (f_dout !== q[0]) begin errors++; $display("[TB] FAIL wrap_fwft: got %h exp %h", f_dout, q[0]); end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 8'h00);
      checks++; if (r_dout !== 8'(8'h18 + i)) begin errors++; $display("[TB] FAIL wrap_tail: got %h exp %h", r_dout, 8'(8'h18 + i)); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 8'(8'h30 + i));
    checks++; if (r_cnt !== 4'd5) begin errors++; $display("[TB] FAIL mid_pre_cnt: got %0d exp 5", r_cnt); end
    rst = 1'b1;
    tick(1'b1, 1'b1, 8'hEE);
    rst = 1'b0;
    checks++; if (r_empty !== 1'b1 || r_cnt !== 4'd0) begin errors++; $display("[TB] FAIL mid_empty: got %b cnt %0d exp 1 0", r_empty, r_cnt); end
    checks++; if (r_dout !== 8'h00 || f_dout !== 8'h00) begin errors++; $display("[TB] FAIL mid_dout: got %h/%h exp 00/00", r_dout, f_dout); end
    tick(1'b0, 1'b0, 8'h00);
    checks++; if (f_empty !== 1'b1 || f_cnt !== 4'd0) begin errors++; $display("[TB] FAIL mid_discard: got %b cnt %0d exp 1 0", f_empty, f_cnt); end
  endtask

  // Random traffic with a slowly drifting write bias so both full and empty are visited.
  task automatic test_random();
    int wbias;
    for (int i = 0; i < 400; i++) begin
      wbias = ((i / 50) % 2 == 0) ? 75 : 25;
      tick(1'($urandom_range(0, 99) < wbias), 1'($urandom_range(0, 99) < 50), 8'($urandom));
      checks++; if (r_cnt !== 4'(q.size()) || f_cnt !== 4'(q.size())) begin errors++; $display("[TB] FAIL rnd_cnt: got %0d/%0d exp %0d", r_cnt, f_cnt, q.size()); end
      checks++; if (r_empty !== (q.size() == 0) || r_full !== (q.size() == DEPTH)) begin errors++; $display("[TB] FAIL rnd_empty_full: got %b%b size %0d", r_empty, r_full, q.size()); end
      checks++; if (r_ae !== (q.size() <= 2) || r_af !== (q.size() >= 6)) begin errors++; $display("[TB] FAIL rnd_thresholds: got %b%b size %0d", r_ae, r_af, q.size()); end
      checks++; if (r_ovf !== exp_ovf || r_unf !== exp_unf) begin errors++; $display("[TB] FAIL rnd_pulses: got %b%b exp %b%b", r_ovf, r_unf, exp_ovf, exp_unf); end
      checks++; if (r_dout !== exp_dout) begin errors++; $display("[TB] FAIL rnd_dout: got %h exp %h", r_dout, exp_dout); end
      if (q.size() > 0) begin
        checks++; if (f_dout !== q[0]) begin errors++; $display("[TB] FAIL rnd_fwft: got %h exp %h", f_dout, q[0]); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; wr = 1'b0; rd = 1'b0; data_in = 8'h00;
    exp_dout = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
